// File: rtl/gate_tt_sequencer.sv
// -----------------------------------------------------------------------------
// gate_tt_sequencer
//
// Self-test sequencer for a small combinational gate. After a start request it
// walks gate_in through every input combination 0 .. 2**N_IN-1. Each vector is
// held for SETTLE cycles, and then one more cycle in which gate_out is compared
// against EXP_TABLE. When the last vector has been sampled it pulses done and
// reports pass, the number of mismatching vectors and the first failing vector.
//
// Parameters
//   N_IN       number of gate inputs (2**N_IN vectors per run)
//   EXP_TABLE  expected gate output, bit k = expected y for gate_in == k
//   SETTLE     cycles gate_in is held before sampling, 1..15
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   start     in   run request, only honoured in IDLE
//   gate_out  in   output of the gate under test
//   gate_in   out  vector driven into the gate under test
//   busy      out  high while a run is in progress (not in the FINISH cycle)
//   done      out  one-cycle completion pulse
//   pass      out  1 when every vector matched; valid from done until next start
//   fail_cnt  out  number of mismatching vectors in the last run
//   fail_idx  out  first mismatching vector, 0 when there was none
// -----------------------------------------------------------------------------
module gate_tt_sequencer #(
  parameter int unsigned            N_IN      = 2,
  parameter logic [(2**N_IN)-1:0]   EXP_TABLE = 4'b0001,
  parameter int unsigned            SETTLE    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              gate_out,
  output logic [N_IN-1:0]   gate_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     fail_cnt,
  output logic [N_IN-1:0]   fail_idx
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  // The settle counter is 4 bits wide, enough for SETTLE up to 15.
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_IDX    = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] IDX_ZERO    = {N_IN{1'b0}};
  localparam logic [N_IN-1:0] IDX_ONE     = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ZERO    = {(N_IN+1){1'b0}};
  localparam logic [N_IN:0]   CNT_ONE     = (N_IN+1)'(1);

  state_t          state_r;
  logic [N_IN-1:0] idx_r;
  logic [3:0]      settle_r;

  logic            mismatch_s;
  logic [N_IN:0]   fail_cnt_nxt_s;
  logic            first_fail_s;

  // Compare the gate output against the expected table entry for this vector.
  always_comb begin
    mismatch_s     = 1'b0;
    fail_cnt_nxt_s = fail_cnt;
    first_fail_s   = 1'b0;
    if (state_r == S_SAMPLE) begin
      mismatch_s = (gate_out != EXP_TABLE[idx_r]);
    end else begin
      mismatch_s = 1'b0;
    end
    if (mismatch_s) begin
      fail_cnt_nxt_s = fail_cnt + CNT_ONE;
      first_fail_s   = (fail_cnt == CNT_ZERO);
    end else begin
      fail_cnt_nxt_s = fail_cnt;
      first_fail_s   = 1'b0;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      idx_r    <= IDX_ZERO;
      settle_r <= 4'd0;
      gate_in  <= IDX_ZERO;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_cnt <= CNT_ZERO;
      fail_idx <= IDX_ZERO;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r  <= S_DRIVE;
            idx_r    <= IDX_ZERO;
            settle_r <= 4'd0;
            gate_in  <= IDX_ZERO;
            fail_cnt <= CNT_ZERO;
            fail_idx <= IDX_ZERO;
            pass     <= 1'b0;
            busy     <= 1'b1;
          end
        end

        S_DRIVE: begin
          gate_in  <= idx_r;
          settle_r <= settle_r + 4'd1;
          if (settle_r == SETTLE_LAST) begin
            state_r <= S_SAMPLE;
          end
        end

        S_SAMPLE: begin
          fail_cnt <= fail_cnt_nxt_s;
          if (first_fail_s) begin
            fail_idx <= idx_r;
          end
          if (idx_r == LAST_IDX) begin
            // pass uses the count including this last sample so that it is
            // already correct in the cycle done is high.
            state_r <= S_FINISH;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (fail_cnt_nxt_s == CNT_ZERO);
          end else begin
            // gate_in moves together with idx so the new vector gets the
            // full SETTLE+1 cycles.
            idx_r    <= idx_r + IDX_ONE;
            gate_in  <= idx_r + IDX_ONE;
            settle_r <= 4'd0;
            state_r  <= S_DRIVE;
          end
        end

        S_FINISH: begin
          done    <= 1'b0;
          state_r <= S_IDLE;
        end

        default: begin
          state_r  <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          settle_r <= 4'd0;
        end
      endcase
    end
  end

  gate_tt_sequencer_checker #(
    .N_IN (N_IN)
  ) u_checker (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_cnt (fail_cnt),
    .fail_idx (fail_idx)
  );

endmodule

// -----------------------------------------------------------------------------
// gate_tt_sequencer_checker
//
// Invariants of the sequencer's reporting outputs.
//
// Ports (all inputs): clk, rst_n, busy, done, pass, fail_cnt, fail_idx
// -----------------------------------------------------------------------------
module gate_tt_sequencer_checker #(
  parameter int unsigned N_IN = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            busy,
  input  logic            done,
  input  logic            pass,
  input  logic [N_IN:0]   fail_cnt,
  input  logic [N_IN-1:0] fail_idx
);

  localparam logic [N_IN:0]   CNT_MAX  = (N_IN+1)'(2**N_IN);
  localparam logic [N_IN:0]   CNT_ZERO = {(N_IN+1){1'b0}};
  localparam logic [N_IN-1:0] IDX_ZERO = {N_IN{1'b0}};

  a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    done |-> !busy);

  a_done_single: assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);

  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    fail_cnt <= CNT_MAX);

  a_idx_zero_without_fail: assert property (@(posedge clk) disable iff (!rst_n)
    (fail_cnt == CNT_ZERO) |-> (fail_idx == IDX_ZERO));

  a_pass_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    done |-> (pass == (fail_cnt == CNT_ZERO)));

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gate_tt_sequencer
//
// Two sequencer instances: the default 2-input NOR setup and a 3-input NOR
// setup with SETTLE=3. A driver issues runs against behavioural gate models and
// pushes the expected result of each run into a scoreboard queue; a monitor
// pops and compares whenever a done pulse appears, and also checks the vector
// trace seen while busy and the values held while idle.
// -----------------------------------------------------------------------------
module tb_gate_tt_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic       gate_out1, gate_out2;
  logic [1:0] gate_in1;
  logic [2:0] gate_in2;
  logic       busy1, busy2, done1, done2, pass1, pass2;
  logic [2:0] fail_cnt1;
  logic [3:0] fail_cnt2;
  logic [1:0] fail_idx1;
  logic [2:0] fail_idx2;

  gate_tt_sequencer dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .gate_out(gate_out1),
    .gate_in(gate_in1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_cnt(fail_cnt1), .fail_idx(fail_idx1)
  );

  gate_tt_sequencer #(.N_IN(3), .EXP_TABLE(8'b00000001), .SETTLE(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .gate_out(gate_out2),
    .gate_in(gate_in2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_cnt(fail_cnt2), .fail_idx(fail_idx2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  // Gate behaviour selection: 0 NOR, 1 stuck at 0, 2 OR, 3 NOR with vector 2
  // forced high, 4 random truth table.
  int         gmode = 0;
  logic [7:0] rand_tt = 8'h00;
  bit         sel = 1'b0;

  function automatic bit gate_fn(input int mode, input int k, input logic [7:0] tt);
    case (mode)
      0:       return (k == 0);
      1:       return 1'b0;
      2:       return (k != 0);
      3:       return (k == 0) || (k == 2);
      default: return tt[k];
    endcase
  endfunction

  assign gate_out1 = gate_fn(gmode, int'(gate_in1), rand_tt);
  assign gate_out2 = gate_fn(gmode, int'(gate_in2), rand_tt);

  typedef struct {
    int issue;
    bit s;
    bit pass;
    int cnt;
    int idx;
  } sb_item_t;

  sb_item_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a NOR is 1 only for the all-zero vector; count disagreements.
  function automatic sb_item_t model(input bit s, input int mode, input logic [7:0] tt);
    sb_item_t r;
    int nv;
    nv = s ? 8 : 4;
    r.issue = 0;
    r.s = s;
    r.cnt = 0;
    r.idx = 0;
    for (int k = 0; k < nv; k++) begin
      if (gate_fn(mode, k, tt) != (k == 0)) begin
        if (r.cnt == 0) r.idx = k;
        r.cnt++;
      end
    end
    r.pass = (r.cnt == 0);
    return r;
  endfunction

  // Monitor state
  int       trace[$];
  sb_item_t e;
  int       hold_pass[2];
  int       hold_cnt[2];
  int       hold_idx[2];
  int       hold_gin[2];
  int       m_gin, m_cnt, m_idx, m_nv, m_st, m_bad;
  bit       m_busy, m_done, m_pass;

  always @(negedge clk) begin
    m_busy = sel ? busy2 : busy1;
    m_done = sel ? done2 : done1;
    m_pass = sel ? pass2 : pass1;
    m_gin  = sel ? int'(gate_in2) : int'(gate_in1);
    m_cnt  = sel ? int'(fail_cnt2) : int'(fail_cnt1);
    m_idx  = sel ? int'(fail_idx2) : int'(fail_idx1);
    m_nv   = sel ? 8 : 4;
    m_st   = sel ? 3 : 1;
    if (!rst_n) begin
      trace.delete();
      for (int i = 0; i < 2; i++) begin
        hold_pass[i] = 0; hold_cnt[i] = 0; hold_idx[i] = 0; hold_gin[i] = 0;
      end
    end else begin
      if (m_busy) trace.push_back(m_gin);
      if (m_done) begin
        n_done++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_dut", int'(sel), int'(e.s));
          chk("done_cycle", cyc, e.issue + m_nv * (m_st + 1) + 1);
          chk("pass", int'(m_pass), int'(e.pass));
          chk("fail_cnt", m_cnt, e.cnt);
          chk("fail_idx", m_idx, e.idx);
          chk("busy_at_done", int'(m_busy), 0);
          chk("trace_len", trace.size(), m_nv * (m_st + 1));
          m_bad = -1;
          for (int i = 0; i < trace.size(); i++) begin
            if (m_bad < 0 && trace[i] != i / (m_st + 1)) m_bad = i;
          end
          chk("trace_first_bad_pos", m_bad, -1);
          hold_pass[sel] = int'(e.pass);
          hold_cnt[sel]  = e.cnt;
          hold_idx[sel]  = e.idx;
          hold_gin[sel]  = m_nv - 1;
        end
        trace.delete();
      end else if (!m_busy) begin
        chk("idle_pass", int'(m_pass), hold_pass[sel]);
        chk("idle_fail_cnt", m_cnt, hold_cnt[sel]);
        chk("idle_fail_idx", m_idx, hold_idx[sel]);
        chk("idle_gate_in", m_gin, hold_gin[sel]);
      end
    end
  end

  task automatic set_start(input bit s, input bit v);
    if (s) start2 = v;
    else   start1 = v;
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 300 && n_done < target; k++) begin
      @(posedge clk); #1;
    end
    chk("done_count", n_done, target);
    if (n_done < target) sb.delete();
  endtask

  task automatic run(input bit s, input int mode);
    sb_item_t it;
    int base;
    sel = s;
    gmode = mode;
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    it = model(s, mode, rand_tt);
    it.issue = cyc;
    sb.push_back(it);
    base = n_done;
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    wait_done(base + 1);
  endtask

  initial begin
    sb_item_t it;
    int base;
    int c;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy1", int'(busy1), 0);
    chk("reset_done1", int'(done1), 0);
    chk("reset_busy2", int'(busy2), 0);
    chk("reset_gate_in2", int'(gate_in2), 0);
    @(posedge clk); #1;

    run(1'b0, 0);   // correct NOR
    run(1'b0, 1);   // stuck at 0
    run(1'b0, 2);   // OR
    run(1'b0, 3);   // NOR with vector 2 wrong

    // start held high across two runs
    sel = 1'b0; gmode = 0;
    base = n_done;
    c = cyc;
    it = model(1'b0, 0, rand_tt);
    it.issue = c;      sb.push_back(it);
    it.issue = c + 10; sb.push_back(it);
    start1 = 1'b1;
    wait_done(base + 2);
    start1 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    // reset in the middle of a run: no done, outputs cleared
    sel = 1'b0; gmode = 2;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrun_reset_busy", int'(busy1), 0);
    chk("midrun_reset_done", int'(done1), 0);
    chk("midrun_reset_fail_cnt", int'(fail_cnt1), 0);
    chk("midrun_reset_gate_in", int'(gate_in1), 0);
    repeat (12) begin @(posedge clk); #1; end

    run(1'b0, 0);   // normal run after reset
    run(1'b1, 0);   // 3-input NOR, SETTLE=3
    run(1'b1, 2);   // 3-input OR

    for (int i = 0; i < 12; i++) begin
      rand_tt = 8'($urandom);
      run(1'($urandom_range(0, 1)), $urandom_range(0, 4));
    end

    repeat (5) begin @(posedge clk); #1; end
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
